// File: rtl/key_event_fifo.sv
// Turns a level-type key report into one event per press and queues the codes in an FWFT FIFO.
// Optional KEY_EVENT_FIFO_AUTOREPEAT_EN adds held-key auto-repeat pushes.
module key_event_fifo #(
    parameter int CODE_W      = 4,
    parameter int DEPTH_LOG2  = 3,
    parameter int REPEAT_DLY  = 5000000,
    parameter int REPEAT_RATE = 1000000
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Valid,
    input  logic [CODE_W-1:0]     Code,
    input  logic                  Rd_En,
    output logic [CODE_W-1:0]     Rd_Data,
    output logic                  Empty,
    output logic                  Full,
    output logic [DEPTH_LOG2:0]   Count,
    output logic                  Overflow,
    input  logic                  Clr_Ovf
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    if (REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat_cfg
        $error("REPEAT_DLY and REPEAT_RATE must be at least 1");
    end

    logic                  valid_d;
    logic                  push_edge;
    logic                  push;
    logic                  pop;
    logic                  wr_en;
    logic                  ovf_set;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [CODE_W-1:0]     mem [DEPTH];
    logic [CODE_W-1:0]     last_q;
    logic                  ovf_q;

    assign push_edge = Valid & ~valid_d;

`ifdef KEY_EVENT_FIFO_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DLY_END  = RPT_W'(REPEAT_DLY - 1);
    localparam logic [RPT_W-1:0] RATE_END = RPT_W'(REPEAT_RATE - 1);

    logic [RPT_W-1:0] hold_cnt;
    logic             rate_phase;
    logic             rpt_push;

    // First repeat waits the long delay, later ones use the shorter rate
    assign rpt_push = Valid & valid_d &
                      (hold_cnt == (rate_phase ? RATE_END : DLY_END));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hold_cnt   <= '0;
            rate_phase <= 1'b0;
        end else if (!Valid || push_edge) begin
            hold_cnt   <= '0;
            rate_phase <= 1'b0;
        end else if (rpt_push) begin
            hold_cnt   <= '0;
            rate_phase <= 1'b1;
        end else begin
            hold_cnt   <= hold_cnt + 1'b1;
        end
    end

    assign push = push_edge | rpt_push;
`else
    assign push = push_edge;
`endif

    assign Empty   = (count == '0);
    assign Full    = (count == FULL_CNT);
    assign Count   = count;
    assign Overflow = ovf_q;

    assign pop     = Rd_En & ~Empty;
    assign wr_en   = push & (~Full | pop);
    assign ovf_set = push & Full & ~pop;

    // last_q keeps the head visible after the final pop empties the queue
    assign Rd_Data = Empty ? last_q : mem[rd_ptr];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            valid_d <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            last_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_d <= Valid;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !wr_en) begin
                count <= count - 1'b1;
            end
            if (!Empty) begin
                last_q <= mem[rd_ptr];
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (Clr_Ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= Code;
        end
    end

endmodule
